fp_mul_pipe: RTL and testbench

Parametrised, pipelined IEEE-754 floating-point multiplier. It is the successor to the single-precision unpack/exponent-add stage in the multiplier project and extends it in four ways: generic exponent and fraction widths, full mantissa multiply with normalisation and rounding, special-value handling, and a valid/ready streaming interface. It sits between the operand issue logic and the result writeback of the arithmetic datapath.

---
 rtl/fp_mul_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined IEEE-754 multiplier (unpack/classify, multiply, normalise/round/pack).
// Build with FP_MUL_RNE_EN defined for round-to-nearest-even; otherwise the result is truncated.
module fp_mul_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] input_a,
    input  logic [EXP_W+FRAC_W:0] input_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] output_z,
    output logic [3:0]            flags
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * FRAC_W + 2;

    localparam logic [EW-1:0] C_BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0] C_EMAX = {2'b00, {EXP_W{1'b1}}};
    localparam logic [W-1:0]  C_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Global stall: the whole pipe freezes while a result waits at the output
    // ------------------------------------------------------------------
    logic w_stall;
    logic w_adv;

    logic r3_valid;
    logic [W-1:0] r3_z;
    logic [3:0]   r3_flags;

    assign w_stall   = r3_valid & ~out_ready;
    assign w_adv     = ~w_stall;
    assign in_ready  = ~w_stall;
    assign out_valid = r3_valid;
    assign output_z  = r3_z;
    assign flags     = r3_flags;

    // ------------------------------------------------------------------
    // S1: unpack and classify both operands
    // ------------------------------------------------------------------
    logic [W-1:0]      w_op      [2];
    logic              w_sign    [2];
    logic [EXP_W-1:0]  w_exp     [2];
    logic [FRAC_W-1:0] w_frac    [2];
    logic              w_is_zero [2];
    logic              w_is_inf  [2];
    logic              w_is_nan  [2];

    assign w_op[0] = input_a;
    assign w_op[1] = input_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign w_sign[gi]    = w_op[gi][W-1];
            assign w_exp[gi]     = w_op[gi][W-2:FRAC_W];
            assign w_frac[gi]    = w_op[gi][FRAC_W-1:0];
            // Subnormals have exp = 0 and are flushed to zero here
            assign w_is_zero[gi] = (w_exp[gi] == '0);
            assign w_is_inf[gi]  = (w_exp[gi] == '1) && (w_frac[gi] == '0);
            assign w_is_nan[gi]  = (w_exp[gi] == '1) && (w_frac[gi] != '0);
        end
    endgenerate

    logic [EW-1:0] w_e_sum;
    logic          w_invalid;
    logic          w_inf;
    logic          w_zero;

    assign w_e_sum   = {2'b00, w_exp[0]} + {2'b00, w_exp[1]} - C_BIAS;
    assign w_invalid = w_is_nan[0] | w_is_nan[1]
                     | (w_is_inf[0] & w_is_zero[1]) | (w_is_zero[0] & w_is_inf[1]);
    assign w_inf     = w_is_inf[0] | w_is_inf[1];
    assign w_zero    = w_is_zero[0] | w_is_zero[1];

    logic              r1_valid;
    logic              r1_sign;
    logic [EW-1:0]     r1_e_sum;
    logic [FRAC_W:0]   r1_sig_a;
    logic [FRAC_W:0]   r1_sig_b;
    logic              r1_invalid;
    logic              r1_inf;
    logic              r1_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1_valid   <= 1'b0;
            r1_sign    <= 1'b0;
            r1_e_sum   <= '0;
            r1_sig_a   <= '0;
            r1_sig_b   <= '0;
            r1_invalid <= 1'b0;
            r1_inf     <= 1'b0;
            r1_zero    <= 1'b0;
        end else if (w_adv) begin
            r1_valid   <= in_valid;
            r1_sign    <= w_sign[0] ^ w_sign[1];
            r1_e_sum   <= w_e_sum;
            r1_sig_a   <= {1'b1, w_frac[0]};
            r1_sig_b   <= {1'b1, w_frac[1]};
            r1_invalid <= w_invalid;
            r1_inf     <= w_inf;
            r1_zero    <= w_zero;
        end
    end

    // ------------------------------------------------------------------
    // S2: full significand product
    // ------------------------------------------------------------------
    logic [PW-1:0] w_prod;
    assign w_prod = PW'(r1_sig_a) * PW'(r1_sig_b);

    logic          r2_valid;
    logic          r2_sign;
    logic [EW-1:0] r2_e_sum;
    logic [PW-1:0] r2_prod;
    logic          r2_invalid;
    logic          r2_inf;
    logic          r2_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r2_valid   <= 1'b0;
            r2_sign    <= 1'b0;
            r2_e_sum   <= '0;
            r2_prod    <= '0;
            r2_invalid <= 1'b0;
            r2_inf     <= 1'b0;
            r2_zero    <= 1'b0;
        end else if (w_adv) begin
            r2_valid   <= r1_valid;
            r2_sign    <= r1_sign;
            r2_e_sum   <= r1_e_sum;
            r2_prod    <= w_prod;
            r2_invalid <= r1_invalid;
            r2_inf     <= r1_inf;
            r2_zero    <= r1_zero;
        end
    end

    // ------------------------------------------------------------------
    // S3: normalise, round, resolve special values, pack
    // ------------------------------------------------------------------
    logic              w_msb;
    logic [FRAC_W-1:0] w_frac_t;
    logic              w_guard;
    logic              w_sticky;
    logic [EW-1:0]     w_e_norm;
    logic [FRAC_W-1:0] w_frac_r;
    logic              w_carry;
    logic [EW-1:0]     w_e_fin;
    logic              w_ovf;
    logic              w_unf;
    logic              w_inexact;

    // Product lies in [1,4): a set MSB means the value is >= 2
    assign w_msb    = r2_prod[PW-1];
    assign w_frac_t = w_msb ? r2_prod[PW-2:FRAC_W+1] : r2_prod[PW-3:FRAC_W];
    assign w_guard  = w_msb ? r2_prod[FRAC_W] : r2_prod[FRAC_W-1];
    assign w_sticky = w_msb ? (|r2_prod[FRAC_W-1:0]) : (|r2_prod[FRAC_W-2:0]);
    assign w_e_norm = r2_e_sum + EW'(w_msb);

`ifdef FP_MUL_RNE_EN
    logic w_round_up;
    assign w_round_up          = w_guard & (w_sticky | w_frac_t[0]);
    // A carry leaves the fraction all-zero, which is exactly the renormalised value
    assign {w_carry, w_frac_r} = {1'b0, w_frac_t} + (FRAC_W+1)'(w_round_up);
`else
    assign w_carry  = 1'b0;
    assign w_frac_r = w_frac_t;
`endif

    assign w_e_fin   = w_e_norm + EW'(w_carry);
    assign w_ovf     = ~w_e_fin[EW-1] && (w_e_fin >= C_EMAX);
    assign w_unf     = w_e_fin[EW-1] || (w_e_fin == '0);
    assign w_inexact = w_guard | w_sticky;

    logic [W-1:0] w_z;
    logic [3:0]   w_flags;

    always_comb begin
        w_z     = {r2_sign, w_e_fin[EXP_W-1:0], w_frac_r};
        w_flags = {3'b000, w_inexact};
        if (r2_invalid) begin
            w_z     = C_QNAN;
            w_flags = 4'b1000;
        end else if (r2_inf) begin
            w_z     = {r2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            w_flags = 4'b0000;
        end else if (r2_zero) begin
            w_z     = {r2_sign, {(W-1){1'b0}}};
            w_flags = 4'b0000;
        end else if (w_ovf) begin
            w_z     = {r2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            w_flags = 4'b0101;
        end else if (w_unf) begin
            w_z     = {r2_sign, {(W-1){1'b0}}};
            w_flags = 4'b0011;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r3_valid <= 1'b0;
            r3_z     <= '0;
            r3_flags <= '0;
        end else if (w_adv) begin
            r3_valid <= r2_valid;
            r3_z     <= w_z;
            r3_flags <= w_flags;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed test-plan vectors plus randomized traffic against an
// arithmetic reference model and a three-slot timing model of the stall/latency rules.
module tb_fp_mul_pipe;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] output_z;
    logic [3:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;

    // Timing model: slot k holds the item accepted k+1 edges ago (slot 2 is visible at the output)
    logic        m_v [3];
    logic [35:0] m_d [3];

    fp_mul_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input_a   (input_a),
        .input_b   (input_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .output_z  (output_z),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Reference: {flags, z} computed from exact integer arithmetic on the operand values
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e, k;
        longint unsigned ma, mb, p, q, rem, half;
        logic s, inexact, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        logic [7:0] e8;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        nan_a  = (ea == 255) && (a[22:0] != 0);
        nan_b  = (eb == 255) && (b[22:0] != 0);
        inf_a  = (ea == 255) && (a[22:0] == 0);
        inf_b  = (eb == 255) && (b[22:0] == 0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        s = a[31] ^ b[31];
        if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b))
            return {4'b1000, 32'h7FC00000};
        if (inf_a || inf_b)
            return {4'b0000, s, 8'hFF, 23'd0};
        if (zero_a || zero_b)
            return {4'b0000, s, 31'd0};
        ma = (64'd1 << 23) + 64'(a[22:0]);
        mb = (64'd1 << 23) + 64'(b[22:0]);
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin
            k = 24;
            e = e + 1;
        end else begin
            k = 23;
        end
        q    = p >> k;
        rem  = p - (q << k);
        half = 64'd1 << (k - 1);
        inexact = (rem != 0);
`ifdef FP_MUL_RNE_EN
        if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
`else
        if (half == 0) q = q + 1;
`endif
        if (q >= (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0011, s, 31'd0};
        e8 = e[7:0];
        return {3'b000, inexact, s, e8, q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] f;
        int sel;
        sel = int'($urandom_range(0, 9));
        case (sel)
            0:       e = 8'd0;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(200, 254));
            3:       e = 8'($urandom_range(1, 40));
            default: e = 8'($urandom_range(100, 154));
        endcase
        f = 23'($urandom);
        if ($urandom_range(0, 7) == 0) f = 23'd0;
        return {1'($urandom), e, f};
    endfunction

    // One clock cycle: drive at negedge, check outputs, advance the timing model at posedge
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic rdy, input logic use_lit, input logic [35:0] lit);
        logic        stall_m;
        logic        acc;
        logic [35:0] e;
        in_valid  = v;
        input_a   = a;
        input_b   = b;
        out_ready = rdy;
        #1;
        stall_m = m_v[2] && !rdy;
        check("out_valid", {35'd0, out_valid}, {35'd0, m_v[2]});
        check("in_ready", {35'd0, in_ready}, {35'd0, !stall_m});
        if (m_v[2]) check("result", {flags, output_z}, m_d[2]);
        if (m_v[2] && rdy) $display("[TB] result z=%h flags=%b", output_z, flags);
        acc = v && !stall_m;
        e   = use_lit ? lit : ref_mul(a, b);
        @(posedge clk);
        if (!stall_m) begin
            m_v[2] = m_v[1]; m_d[2] = m_d[1];
            m_v[1] = m_v[0]; m_d[1] = m_d[0];
            m_v[0] = acc;    m_d[0] = e;
        end
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [35:0] lit);
        step(1'b1, a, b, 1'b1, 1'b1, lit);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 36'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = 36'd0;
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; input_a = '0; input_b = '0;
        #3;
        check("rst_out_valid", {35'd0, out_valid}, 36'd0);
        check("rst_output", {flags, output_z}, 36'd0);
        check("rst_in_ready", {35'd0, in_ready}, 36'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Basic products and latency
        push(32'h40000000, 32'h40400000, {4'b0000, 32'h40C00000});
        push(32'hC0000000, 32'h40400000, {4'b0000, 32'hC0C00000});
        idle(4);

        // Back-to-back throughput
        for (int i = 0; i < 8; i++) push(32'h3FC00000, 32'h3FC00000, {4'b0000, 32'h40100000});
        idle(3);

        // Rounding
`ifdef FP_MUL_RNE_EN
        push(32'h3FC00001, 32'h3FC00001, {4'b0001, 32'h40100002});
`else
        push(32'h3FC00001, 32'h3FC00001, {4'b0001, 32'h40100001});
`endif
        // Special values
        push(32'h7F800000, 32'h00000000, {4'b1000, 32'h7FC00000});
        push(32'h7F000000, 32'h7F000000, {4'b0101, 32'h7F800000});
        push(32'h00800000, 32'h00800000, {4'b0011, 32'h00000000});
        push(32'h80000000, 32'h3F800000, {4'b0000, 32'h80000000});
        push(32'h7FC12345, 32'h3F800000, {4'b1000, 32'h7FC00000});
        push(32'hFF800000, 32'h40000000, {4'b0000, 32'hFF800000});
        idle(3);

        // Stall with a full pipeline
        push(32'h40000000, 32'h40000000, {4'b0000, 32'h40800000});
        push(32'h40400000, 32'h40000000, {4'b0000, 32'h40C00000});
        push(32'h40800000, 32'h40000000, {4'b0000, 32'h41000000});
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1, {4'b0000, 32'h3F800000});
        push(32'h3F800000, 32'h3F800000, {4'b0000, 32'h3F800000});
        idle(4);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), rnd_op(), rnd_op(),
                 1'($urandom_range(0, 4) != 0), 1'b0, 36'd0);
        idle(4);

        // Reset with three results in flight
        push(32'h40000000, 32'h40000000, {4'b0000, 32'h40800000});
        push(32'h40400000, 32'h40400000, {4'b0000, 32'h41100000});
        push(32'h40800000, 32'h40800000, {4'b0000, 32'h41800000});
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", {35'd0, out_valid}, 36'd0);
        check("midrst_output", {flags, output_z}, 36'd0);
        check("midrst_in_ready", {35'd0, in_ready}, 36'd1);
        for (int i = 0; i < 3; i++) m_v[i] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        push(32'h40000000, 32'h40400000, {4'b0000, 32'h40C00000});
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
